board_controller: RTL and testbench
===================================

Name: board_controller

Overview:
- Upstream stage of the win detector. Owns the 3x3 board registers and alternates turns between player 1 and player 2.
- Accepts one-cycle move requests from the input/debounce logic and rejects illegal moves.
- Drives pos1..pos9 into the win detector, waits out the detector's registered latency, then reads win back to decide: continue, win, or draw.
- Freezes the board when the game ends, until a new-game request.

Parameters:
- FIRST_PLAYER, 2'b01: player that moves first after reset or new_game (2'b01 = P1, 2'b10 = P2).
- DETECT_LATENCY, 1: number of clk register stages between pos* and win in the win detector (1..3).

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- new_game  in  1  one-cycle pulse; clears board, restarts game
- move_valid  in  1  one-cycle pulse; request to play move_sel
- move_sel  in  4  square index 1..9 (1 = top-left, row-major)
- win  in  2  from win detector: 00 none, 01 P1, 10 P2, 11 ignored (treated as 00)
- pos1..pos9  out  2 each  square contents: 00 empty, 01 P1, 10 P2
- turn  out  2  player to move (01/10)
- busy  out  1  high while in SETTLE or EVAL (move not accepted)
- illegal  out  1  one-cycle pulse on rejected move
- game_over  out  1  high in OVER
- winner  out  2  latched result in OVER: 01 P1, 10 P2, 00 draw; 00 outside OVER
- move_count  out  4  moves placed this game, 0..9

Behaviour:
- Reset (rst_n low, async): all pos* = 00, turn = FIRST_PLAYER, state = PLAY, move_count = 0, busy = 0, illegal = 0, game_over = 0, winner = 00.
- States: PLAY, SETTLE, EVAL, OVER. A settle counter, width ceil(log2(DETECT_LATENCY+1)), is used only in SETTLE.
- PLAY:
  - A move_valid pulse is legal when move_sel is in 1..9 and the selected pos is 00.
  - Legal move: on that edge, pos[move_sel] <= turn, move_count += 1, counter <= DETECT_LATENCY, next state SETTLE.
  - Illegal move (sel 0 or 10..15, or square occupied): illegal = 1 for exactly the next cycle. Board, turn and count are unchanged; stay in PLAY.
- SETTLE: counter decrements each cycle. When it reaches 0, go to EVAL. Total time from the accept edge to EVAL entry is DETECT_LATENCY cycles; win is valid throughout EVAL.
- EVAL (one cycle; decision made on the exit edge):
  - win = 01 or 10: go to OVER, winner <= win.
  - Otherwise, move_count = 9: go to OVER, winner <= 00 (draw).
  - Otherwise: turn toggles (01 <-> 10), go to PLAY.
- busy = 1 in SETTLE and EVAL. move_valid in SETTLE, EVAL or OVER is ignored: no illegal pulse, no state change.
- OVER: board, turn, move_count and winner all hold; game_over = 1. Stays in OVER until new_game.
- new_game (any state, highest priority after reset):
  - On that edge: all pos* = 00, turn = FIRST_PLAYER, move_count = 0, winner = 00, game_over = 0, illegal = 0, state = PLAY.
  - A move_valid in the same cycle is dropped.
- win = 11 or a stale win value seen outside EVAL is ignored.
- Outputs are registered; no combinational path from inputs to outputs.
- Latency with DETECT_LATENCY = 1:
  - move_valid sampled at edge E0 -> pos visible after E0.
  - EVAL occupies the cycle after E1.
  - turn toggles, or game_over rises, after E2.
  - The next move is accepted from E2 onward, i.e. 2 cycles after a legal move.
- move_count saturates logically at 9; reaching 9 always forces OVER in EVAL.

Test Plan:
- Reset, then play sel 1, 4, 2, 5, 3 with a behavioural 1-cycle win detector -> pos1..3 = 01, pos4..5 = 10; game_over rises 2 cycles after the 5th move; winner = 01; move_count = 5; turn frozen at 01.
- Play sel 5, then sel 5 again -> second request gives illegal = 1 for 1 cycle; pos5 stays 01; turn stays 10; move_count = 1. Also sel = 0 and sel = 12 -> illegal pulse, no change.
- Fill all 9 squares in a draw sequence (5, 1, 9, 3, 2, 8, 7, 4, 6) -> after the 9th EVAL, game_over = 1, winner = 00, move_count = 9.
- move_valid asserted during SETTLE/EVAL, and move_valid asserted in OVER -> no illegal pulse; board unchanged.
- new_game in OVER, and new_game together with move_valid in PLAY -> board all 00, turn = FIRST_PLAYER, count = 0, game_over = 0; move dropped.
- rst_n asserted asynchronously mid-SETTLE, and DETECT_LATENCY = 3 -> outputs clear immediately without a clock; with latency 3, EVAL occurs 3 cycles after accept and turn toggles 4 cycles after accept.

Source files
------------

// File: rtl/board_controller_if.sv
// Move-request and board/status bundle between the input logic, the board
// controller and the win detector.
interface board_controller_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_sel;
    logic [1:0] win;
    logic [1:0] pos1;
    logic [1:0] pos2;
    logic [1:0] pos3;
    logic [1:0] pos4;
    logic [1:0] pos5;
    logic [1:0] pos6;
    logic [1:0] pos7;
    logic [1:0] pos8;
    logic [1:0] pos9;
    logic [1:0] turn;
    logic       busy;
    logic       illegal;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] move_count;

    modport master (
        output new_game, move_valid, move_sel, win,
        input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  turn, busy, illegal, game_over, winner, move_count
    );

    modport slave (
        input  new_game, move_valid, move_sel, win,
        output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output turn, busy, illegal, game_over, winner, move_count
    );
endinterface

// File: rtl/board_controller.sv
// Tic-tac-toe board owner: validates moves, alternates turns, waits out the
// win detector latency and decides continue / win / draw.
module board_controller #(
    parameter logic [1:0] FIRST_PLAYER   = 2'b01,
    parameter int         DETECT_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    board_controller_if.slave  bus
);

    localparam int CNT_W = (DETECT_LATENCY < 1) ? 1 : $clog2(DETECT_LATENCY + 1);

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        SETTLE = 2'd1,
        EVAL   = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         turn_reg, turn_next;
    logic [3:0]         count_reg, count_next;
    logic [1:0]         winner_reg, winner_next;
    logic               illegal_reg, illegal_next;

    logic               place_move;
    logic               clear_board;
    logic [8:0]         sel_hit;
    logic [8:0]         occupied;
    logic [8:0][1:0]    board;
    logic               sel_ok;

    // One register per square; a square is written only by the accepted move
    // that selects it, or cleared by new_game.
    for (genvar gi = 0; gi < 9; gi++) begin : g_sq
        logic [1:0] sq_reg, sq_next;

        assign sel_hit[gi]  = (bus.move_sel == 4'(gi + 1));
        assign occupied[gi] = (sq_reg != 2'b00);
        assign board[gi]    = sq_reg;

        always_comb begin
            sq_next = sq_reg;
            if (clear_board) begin
                sq_next = 2'b00;
            end else if (place_move && sel_hit[gi]) begin
                sq_next = turn_reg;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sq_reg <= 2'b00;
            end else begin
                sq_reg <= sq_next;
            end
        end
    end

    // Selects 0 and 10..15 hit no square, so they fail the range test here.
    assign sel_ok = (|sel_hit) && !(|(sel_hit & occupied));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= PLAY;
            cnt_reg     <= '0;
            turn_reg    <= FIRST_PLAYER;
            count_reg   <= 4'd0;
            winner_reg  <= 2'b00;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            turn_reg    <= turn_next;
            count_reg   <= count_next;
            winner_reg  <= winner_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        turn_next    = turn_reg;
        count_next   = count_reg;
        winner_next  = winner_reg;
        illegal_next = 1'b0;
        place_move   = 1'b0;
        clear_board  = 1'b0;

        if (bus.new_game) begin
            state_next  = PLAY;
            cnt_next    = '0;
            turn_next   = FIRST_PLAYER;
            count_next  = 4'd0;
            winner_next = 2'b00;
            clear_board = 1'b1;
        end else begin
            case (state_reg)
                PLAY: begin
                    if (bus.move_valid) begin
                        if (sel_ok) begin
                            place_move = 1'b1;
                            count_next = count_reg + 4'd1;
                            cnt_next   = CNT_W'(DETECT_LATENCY);
                            state_next = SETTLE;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // Leaving on the count-1 edge makes EVAL start exactly
                    // DETECT_LATENCY cycles after the accepting edge.
                    if (cnt_reg <= CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = EVAL;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (bus.win == 2'b01 || bus.win == 2'b10) begin
                        winner_next = bus.win;
                        state_next  = OVER;
                    end else if (count_reg == 4'd9) begin
                        winner_next = 2'b00;
                        state_next  = OVER;
                    end else begin
                        turn_next  = (turn_reg == 2'b01) ? 2'b10 : 2'b01;
                        state_next = PLAY;
                    end
                end
                default: begin
                    state_next = OVER;
                end
            endcase
        end
    end

    assign bus.pos1       = board[0];
    assign bus.pos2       = board[1];
    assign bus.pos3       = board[2];
    assign bus.pos4       = board[3];
    assign bus.pos5       = board[4];
    assign bus.pos6       = board[5];
    assign bus.pos7       = board[6];
    assign bus.pos8       = board[7];
    assign bus.pos9       = board[8];
    assign bus.turn       = turn_reg;
    assign bus.busy       = (state_reg == SETTLE) || (state_reg == EVAL);
    assign bus.illegal    = illegal_reg;
    assign bus.game_over  = (state_reg == OVER);
    assign bus.winner     = winner_reg;
    assign bus.move_count = count_reg;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: one instance with a 1-stage win
// detector (P1 first), one with a 3-stage detector (P2 first).
module tb_board_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    board_controller_if bus1();
    board_controller_if bus3();

    board_controller #(.FIRST_PLAYER(2'b01), .DETECT_LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    board_controller #(.FIRST_PLAYER(2'b10), .DETECT_LATENCY(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] b1, b3;
    assign b1 = {bus1.pos9, bus1.pos8, bus1.pos7, bus1.pos6, bus1.pos5,
                 bus1.pos4, bus1.pos3, bus1.pos2, bus1.pos1};
    assign b3 = {bus3.pos9, bus3.pos8, bus3.pos7, bus3.pos6, bus3.pos5,
                 bus3.pos4, bus3.pos3, bus3.pos2, bus3.pos1};

    // Behavioural win detector: square n lives at bits 2(n-1)+:2.
    function automatic logic [1:0] judge(input logic [17:0] b);
        int ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                          '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        logic [1:0] a, c, d;
        for (int l = 0; l < 8; l++) begin
            a = b[2*(ln[l][0]-1) +: 2];
            c = b[2*(ln[l][1]-1) +: 2];
            d = b[2*(ln[l][2]-1) +: 2];
            if (a != 2'b00 && a == c && a == d) return a;
        end
        return 2'b00;
    endfunction

    logic [1:0] d3_s1, d3_s2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus1.win <= 2'b00;
            d3_s1    <= 2'b00;
            d3_s2    <= 2'b00;
            bus3.win <= 2'b00;
        end else begin
            bus1.win <= judge(b1);
            d3_s1    <= judge(b3);
            d3_s2    <= d3_s1;
            bus3.win <= d3_s2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move1(input logic [3:0] sel);
        bus1.move_sel   = sel;
        bus1.move_valid = 1'b1;
        tick();
        bus1.move_valid = 1'b0;
        $display("dut1 move sel=%0d board=%05h turn=%0h illegal=%0b count=%0d busy=%0b",
                 sel, b1, bus1.turn, bus1.illegal, bus1.move_count, bus1.busy);
    endtask

    task automatic play1(input logic [3:0] sel);
        move1(sel);
        tick();
        tick();
    endtask

    task automatic new_game1();
        bus1.new_game = 1'b1;
        tick();
        bus1.new_game = 1'b0;
        $display("dut1 new_game board=%05h turn=%0h count=%0d", b1, bus1.turn, bus1.move_count);
    endtask

    initial begin
        rst_n = 1'b1;
        bus1.new_game = 1'b0; bus1.move_valid = 1'b0; bus1.move_sel = 4'd0;
        bus3.new_game = 1'b0; bus3.move_valid = 1'b0; bus3.move_sel = 4'd0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_board1", b1, 18'd0);
        check("rst_turn1", bus1.turn, 2'b01);
        check("rst_turn3", bus3.turn, 2'b10);
        check("rst_busy1", bus1.busy, 1'b0);
        check("rst_illegal1", bus1.illegal, 1'b0);
        check("rst_over1", bus1.game_over, 1'b0);
        check("rst_winner1", bus1.winner, 2'b00);
        check("rst_count1", bus1.move_count, 4'd0);
        #10 rst_n = 1'b1;
        tick();

        // P1 wins the top row
        play1(4'd1); play1(4'd4); play1(4'd2); play1(4'd5);
        move1(4'd3);
        check("win_over_e0", bus1.game_over, 1'b0);
        tick();
        check("win_over_e1", bus1.game_over, 1'b0);
        check("win_busy_e1", bus1.busy, 1'b1);
        tick();
        check("win_over_e2", bus1.game_over, 1'b1);
        check("win_winner", bus1.winner, 2'b01);
        check("win_count", bus1.move_count, 4'd5);
        check("win_turn", bus1.turn, 2'b01);
        check("win_board", b1, {2'b00,2'b00,2'b00,2'b00,2'b10,2'b10,2'b01,2'b01,2'b01});

        move1(4'd6);
        check("over_illegal", bus1.illegal, 1'b0);
        check("over_board", b1, {2'b00,2'b00,2'b00,2'b00,2'b10,2'b10,2'b01,2'b01,2'b01});
        check("over_count", bus1.move_count, 4'd5);
        check("over_hold", bus1.game_over, 1'b1);

        new_game1();
        check("ng_board", b1, 18'd0);
        check("ng_turn", bus1.turn, 2'b01);
        check("ng_count", bus1.move_count, 4'd0);
        check("ng_over", bus1.game_over, 1'b0);
        check("ng_winner", bus1.winner, 2'b00);

        // Illegal requests
        play1(4'd5);
        check("p5_turn", bus1.turn, 2'b10);
        move1(4'd5);
        check("occ_illegal", bus1.illegal, 1'b1);
        tick();
        check("occ_illegal_drop", bus1.illegal, 1'b0);
        move1(4'd0);
        check("sel0_illegal", bus1.illegal, 1'b1);
        tick();
        move1(4'd12);
        check("sel12_illegal", bus1.illegal, 1'b1);
        tick();
        check("ill_board", b1, {2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,2'b00,2'b00,2'b00});
        check("ill_turn", bus1.turn, 2'b10);
        check("ill_count", bus1.move_count, 4'd1);
        check("ill_busy", bus1.busy, 1'b0);

        // Requests during SETTLE and EVAL are ignored
        move1(4'd1);
        move1(4'd2);
        check("settle_ignore", bus1.illegal, 1'b0);
        move1(4'd3);
        check("eval_ignore", bus1.illegal, 1'b0);
        check("busy_turn", bus1.turn, 2'b01);
        check("busy_board", b1, {2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,2'b00,2'b00,2'b10});
        check("busy_count", bus1.move_count, 4'd2);

        // new_game wins over a simultaneous move
        bus1.move_sel   = 4'd7;
        bus1.move_valid = 1'b1;
        new_game1();
        bus1.move_valid = 1'b0;
        check("ngmv_board", b1, 18'd0);
        check("ngmv_count", bus1.move_count, 4'd0);
        check("ngmv_turn", bus1.turn, 2'b01);
        check("ngmv_busy", bus1.busy, 1'b0);

        // Draw
        play1(4'd5); play1(4'd1); play1(4'd9); play1(4'd3);
        play1(4'd2); play1(4'd8); play1(4'd7); play1(4'd4);
        check("draw_turn8", bus1.turn, 2'b01);
        move1(4'd6);
        tick();
        check("draw_over_e1", bus1.game_over, 1'b0);
        tick();
        check("draw_over", bus1.game_over, 1'b1);
        check("draw_winner", bus1.winner, 2'b00);
        check("draw_count", bus1.move_count, 4'd9);
        check("draw_board", b1, {2'b01,2'b10,2'b01,2'b01,2'b01,2'b10,2'b10,2'b01,2'b10});
        new_game1();

        // Latency 3 instance, P2 first
        bus3.move_sel   = 4'd1;
        bus3.move_valid = 1'b1;
        tick();
        bus3.move_valid = 1'b0;
        $display("dut3 move sel=1 board=%05h turn=%0h busy=%0b", b3, bus3.turn, bus3.busy);
        check("l3_board", b3, {2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b10});
        check("l3_busy_e0", bus3.busy, 1'b1);
        tick(); tick(); tick();
        check("l3_turn_e3", bus3.turn, 2'b10);
        check("l3_busy_e3", bus3.busy, 1'b1);
        tick();
        check("l3_turn_e4", bus3.turn, 2'b01);
        check("l3_busy_e4", bus3.busy, 1'b0);

        // Asynchronous reset in the middle of SETTLE
        bus3.move_sel   = 4'd2;
        bus3.move_valid = 1'b1;
        tick();
        bus3.move_valid = 1'b0;
        $display("dut3 move sel=2 board=%05h turn=%0h busy=%0b", b3, bus3.turn, bus3.busy);
        check("l3_p2_board", b3, {2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b01,2'b10});
        #2 rst_n = 1'b0;
        #1;
        check("arst_board", b3, 18'd0);
        check("arst_busy", bus3.busy, 1'b0);
        check("arst_turn", bus3.turn, 2'b10);
        check("arst_count", bus3.move_count, 4'd0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_idle", bus3.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
